// File: rtl/mantissa_align_ctrl.sv
// Alignment front end of the FP adder: picks the larger-exponent operand and
// right-shifts the other mantissa one bit per clock, collecting guard/round/sticky.
module mantissa_align_ctrl #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [MANT_W-1:0] mant_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_big,
    output logic [MANT_W-1:0] mant_small,
    output logic [2:0]        grs,
    output logic              swapped,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Beyond MANT_W+1 positions every mantissa bit lands in sticky.
    localparam logic [EXP_W-1:0] SAT_DIFF = EXP_W'(MANT_W + 2);

    logic [1:0]        r_state;
    logic [EXP_W-1:0]  r_cnt;
    logic [EXP_W-1:0]  r_exp_out;
    logic [MANT_W-1:0] r_mant_big;
    logic [MANT_W-1:0] r_mant_small;
    logic [2:0]        r_grs;
    logic              r_swapped;

    logic              w_b_big;
    logic [EXP_W-1:0]  w_exp_big;
    logic [EXP_W-1:0]  w_diff;
    logic [MANT_W-1:0] w_mant_big;
    logic [MANT_W-1:0] w_mant_small;

    // One-bit right shift: the LSB becomes guard, old guard becomes round,
    // and old round folds into sticky.
    function automatic logic [2:0] f_grs_step(input logic [MANT_W-1:0] m,
                                              input logic [2:0]        g);
        return {m[0], g[2], g[1] | g[0]};
    endfunction

    function automatic logic [2:0] f_grs_sat(input logic [MANT_W-1:0] m);
        return {2'b00, |m};
    endfunction

    assign w_b_big      = (exp_b > exp_a);
    assign w_exp_big    = w_b_big ? exp_b  : exp_a;
    assign w_diff       = w_b_big ? (exp_b - exp_a) : (exp_a - exp_b);
    assign w_mant_big   = w_b_big ? mant_b : mant_a;
    assign w_mant_small = w_b_big ? mant_a : mant_b;

    assign in_ready   = (r_state == S_IDLE) & ~Clear;
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign exp_out    = r_exp_out;
    assign mant_big   = r_mant_big;
    assign mant_small = r_mant_small;
    assign grs        = r_grs;
    assign swapped    = r_swapped;

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_exp_out    <= '0;
            r_mant_big   <= '0;
            r_mant_small <= '0;
            r_grs        <= '0;
            r_swapped    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_swapped  <= w_b_big;
                        r_exp_out  <= w_exp_big;
                        r_mant_big <= w_mant_big;
                        r_cnt      <= w_diff;
                        if (w_diff == '0) begin
                            r_mant_small <= w_mant_small;
                            r_grs        <= 3'b000;
                            r_state      <= S_DONE;
                        end else if (w_diff >= SAT_DIFF) begin
                            r_mant_small <= '0;
                            r_grs        <= f_grs_sat(w_mant_small);
                            r_state      <= S_DONE;
                        end else begin
                            r_mant_small <= w_mant_small;
                            r_grs        <= 3'b000;
                            r_state      <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_mant_small <= r_mant_small >> 1;
                    r_grs        <= f_grs_step(r_mant_small, r_grs);
                    r_cnt        <= r_cnt - EXP_W'(1);
                    if (r_cnt == EXP_W'(1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_align_ctrl.sv
// Directed bench for mantissa_align_ctrl with hand-computed expected results.
module tb_mantissa_align_ctrl;

    logic        Clk;
    logic        Clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_a;
    logic [23:0] mant_a;
    logic [7:0]  exp_b;
    logic [23:0] mant_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [23:0] mant_big;
    logic [23:0] mant_small;
    logic [2:0]  grs;
    logic        swapped;
    logic        busy;

    int n_checks;
    int n_errors;

    mantissa_align_ctrl #(.MANT_W(24), .EXP_W(8)) dut (
        .Clk        (Clk),
        .Clear      (Clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .mant_a     (mant_a),
        .exp_b      (exp_b),
        .mant_b     (mant_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .grs        (grs),
        .swapped    (swapped),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one operand pair, measure latency, check the result, optionally
    // stall the output for hold cycles, then complete the handshake.
    task automatic run_op(input string tag,
                          input logic [7:0] ea, input logic [23:0] ma,
                          input logic [7:0] eb, input logic [23:0] mb,
                          input int exp_lat, input logic exp_sw,
                          input logic [7:0] exp_e, input logic [23:0] exp_big,
                          input logic [23:0] exp_small, input logic [2:0] exp_grs,
                          input int hold);
        int lat;
        exp_a = ea; mant_a = ma; exp_b = eb; mant_b = mb;
        in_valid = 1'b1;
        check_val({tag, "_in_ready_pre"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_swapped"}, {31'd0, swapped}, {31'd0, exp_sw});
        check_val({tag, "_exp_out"}, {24'd0, exp_out}, {24'd0, exp_e});
        check_val({tag, "_mant_big"}, {8'd0, mant_big}, {8'd0, exp_big});
        check_val({tag, "_mant_small"}, {8'd0, mant_small}, {8'd0, exp_small});
        check_val({tag, "_grs"}, {29'd0, grs}, {29'd0, exp_grs});
        for (int i = 0; i < hold; i++) begin
            // Offer a different pair meanwhile; it must be ignored.
            in_valid = 1'b1; exp_a = 8'h01; exp_b = 8'hFE; mant_a = 24'h123456; mant_b = 24'h654321;
            tick();
            check_val({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check_val({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check_val({tag, "_hold_small"}, {8'd0, mant_small}, {8'd0, exp_small});
            check_val({tag, "_hold_grs"}, {29'd0, grs}, {29'd0, exp_grs});
            check_val({tag, "_hold_exp"}, {24'd0, exp_out}, {24'd0, exp_e});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, "_post_big_kept"}, {8'd0, mant_big}, {8'd0, exp_big});
    endtask

    initial begin
        int seen_valid;
        n_checks = 0;
        n_errors = 0;
        Clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_a = '0; mant_a = '0; exp_b = '0; mant_b = '0;
        #2 Clear = 1'b1;
        #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_mant_small", {8'd0, mant_small}, 32'd0);
        check_val("rst_grs", {29'd0, grs}, 32'd0);
        tick();
        @(negedge Clk);
        Clear = 1'b0;
        #1;
        check_val("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        run_op("eq",    8'h7F, 24'h800000, 8'h7F, 24'hC00000, 1,  1'b0, 8'h7F, 24'h800000, 24'hC00000, 3'b000, 0);
        run_op("diff3", 8'h82, 24'hC00000, 8'h7F, 24'h800005, 4,  1'b0, 8'h82, 24'hC00000, 24'h100000, 3'b101, 0);
        run_op("sat",   8'h10, 24'h000001, 8'h90, 24'hA00000, 1,  1'b1, 8'h90, 24'hA00000, 24'h000000, 3'b001, 0);
        run_op("d25",   8'h99, 24'h800000, 8'h80, 24'h800000, 26, 1'b0, 8'h99, 24'h800000, 24'h000000, 3'b010, 0);
        run_op("d26",   8'h9A, 24'h800000, 8'h80, 24'h800000, 1,  1'b0, 8'h9A, 24'h800000, 24'h000000, 3'b001, 0);
        run_op("bp",    8'h81, 24'h800000, 8'h7F, 24'h800003, 3,  1'b0, 8'h81, 24'h800000, 24'h200000, 3'b110, 5);

        // Abort a diff-10 shift after four shift edges.
        exp_a = 8'h8A; mant_a = 24'h800000; exp_b = 8'h80; mant_b = 24'hFFFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_val("clr_pre_busy", {31'd0, busy}, 32'd1);
        Clear = 1'b1;
        #1;
        check_val("clr_busy", {31'd0, busy}, 32'd0);
        check_val("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("clr_exp_out", {24'd0, exp_out}, 32'd0);
        check_val("clr_mant_big", {8'd0, mant_big}, 32'd0);
        check_val("clr_mant_small", {8'd0, mant_small}, 32'd0);
        check_val("clr_in_ready_held", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge Clk);
        Clear = 1'b0;
        #1;
        check_val("clr_release_in_ready", {31'd0, in_ready}, 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        check_val("clr_no_valid", seen_valid, 0);

        run_op("d10",   8'h8A, 24'h800000, 8'h80, 24'hFFFFFF, 11, 1'b0, 8'h8A, 24'h800000, 24'h003FFF, 3'b111, 0);
        run_op("swap4", 8'h70, 24'hF00000, 8'h74, 24'hAAAAAA, 5,  1'b1, 8'h74, 24'hAAAAAA, 24'h0F0000, 3'b000, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
